// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Programmable-rate tick generator driving a loadable countdown
//               timer with synchronous restart and pause. Emits a one-cycle
//               tick enable per divider period while running and a one-cycle
//               expired pulse when the countdown reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer #(
    parameter int unsigned CLK_FREQ = 27000000,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned VAL_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_timer,
    input  logic [VAL_W-1:0] value,
    input  logic             pause,
    output logic             one_hz_enable,
    output logic             expired,
    output logic [VAL_W-1:0] count,
    output logic             busy
);

    // Divider period in clock cycles; must be an exact integer of at least 2.
    localparam int unsigned C_DIV   = CLK_FREQ / TICK_HZ;
    localparam int unsigned C_DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(C_DIV - 1);
    localparam logic [VAL_W-1:0]   C_ONE      = VAL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [C_DIV_W-1:0] div_q,   div_d;
    logic [VAL_W-1:0]   count_q, count_d;
    logic               tick_q,  tick_d;
    logic               exp_q,   exp_d;
    logic               busy_q,  busy_d;

    // State and output registers; reset overrides every other update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            exp_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: start has priority over pause and over a pending tick.
    // A paused state leaving pause on this edge advances the divider at once,
    // so exactly the cycles sampled with pause high are lost.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        count_d = count_q;
        tick_d  = 1'b0;
        exp_d   = 1'b0;

        if (start_timer) begin
            div_d   = '0;
            count_d = value;
            if (value != '0) begin
                state_d = ST_RUN;
            end else begin
                // Zero-length interval completes immediately.
                state_d = ST_IDLE;
                exp_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    div_d = '0;
                end
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                        if (div_q == C_DIV_LAST) begin
                            div_d  = '0;
                            tick_d = 1'b1;
                            if (count_q != '0) begin
                                count_d = count_q - C_ONE;
                                if (count_q == C_ONE) begin
                                    exp_d   = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            end
                        end else begin
                            div_d = div_q + C_DIV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign one_hz_enable = tick_q;
    assign expired       = exp_q;
    assign count         = count_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer
// Description : Scoreboard bench for interval_timer. The stimulus process
//               predicts each cycle's outputs from an elapsed-time model and
//               queues them; a monitor pops and compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer;

    localparam int unsigned CLK_FREQ = 10;
    localparam int unsigned TICK_HZ  = 1;
    localparam int unsigned VAL_W    = 4;
    localparam int          DIV      = CLK_FREQ / TICK_HZ;

    logic             clock = 1'b0;
    logic             reset;
    logic             start_timer;
    logic [VAL_W-1:0] value;
    logic             pause;
    logic             one_hz_enable;
    logic             expired;
    logic [VAL_W-1:0] count;
    logic             busy;

    interval_timer #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .VAL_W    (VAL_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .value         (value),
        .pause         (pause),
        .one_hz_enable (one_hz_enable),
        .expired       (expired),
        .count         (count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit tick;
        bit exp;
        bit busy;
        int cnt;
    } resp_t;

    resp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    // Reference model: interval described by its length N (ticks) and the
    // number of unpaused cycles e elapsed since the start edge.
    bit m_active = 0;
    int m_n      = 0;
    int m_e      = 0;
    int m_cnt    = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge.
    task automatic step(input bit s, input int v, input bit p, input bit r);
        resp_t e;
        reset       = r;
        start_timer = s;
        value       = VAL_W'(v);
        pause       = p;
        e.tick = 0;
        e.exp  = 0;
        if (r) begin
            m_active = 0;
            m_cnt    = 0;
        end else if (s) begin
            m_n      = v;
            m_e      = 0;
            m_cnt    = v;
            m_active = (v != 0);
            e.exp    = (v == 0);
        end else if (m_active && !p) begin
            m_e++;
            e.tick = (m_e % DIV) == 0;
            m_cnt  = m_n - m_e / DIV;
            if (m_e == m_n * DIV) begin
                e.exp    = 1;
                m_active = 0;
            end
        end
        e.busy = m_active;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) step(0, 0, p, 0);
    endtask

    // Monitor: compare the queued prediction just after each rising edge.
    initial begin
        resp_t r;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("tick",    int'(one_hz_enable), int'(r.tick));
                check("expired", int'(expired),       int'(r.exp));
                check("busy",    int'(busy),          int'(r.busy));
                check("count",   int'(count),         r.cnt);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        start_timer = 1'b0;
        value       = '0;
        pause       = 1'b0;
        @(negedge clock);

        // Reset held, then released with nothing started.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        idle(50, 0);

        // Plain countdown of 3 ticks.
        step(1, 3, 0, 0);
        idle(35, 0);

        // Countdown of 5 with a 7-cycle pause starting 4 cycles in.
        step(1, 5, 0, 0);
        idle(3, 0);
        idle(7, 1);
        idle(55, 0);

        // Restart mid-interval with a shorter value.
        step(1, 4, 0, 0);
        idle(24, 0);
        step(1, 2, 0, 0);
        idle(30, 0);

        // Zero-length interval.
        step(1, 0, 0, 0);
        idle(5, 0);

        // Reset mid-run at count 2 / divider 6, then pause while idle.
        step(1, 4, 0, 0);
        idle(26, 0);
        step(0, 0, 0, 1);
        idle(5, 1);
        idle(5, 0);

        // Held start never ticks; pause during start is overridden.
        for (int i = 0; i < 25; i++) step(1, 7, i % 2, 0);
        idle(80, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit s, p, r;
            int v;
            r = ($urandom_range(0, 599) == 0);
            s = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            p = (pause && $urandom_range(0, 9) != 0) || (!pause && $urandom_range(0, 24) == 0);
            step(s, v, p, r);
        end
        idle(3, 0);

        // Every prediction must have been consumed by the monitor.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
